// File: rtl/sha256_drv_pkg.sv
// Shared constants for the SHA-256 core driver: FSM state codes, core command
// bit positions and default block/digest/timeout sizes.
package sha256_drv_pkg;

    localparam int BLK_WORDS = 16;
    localparam int DIG_WORDS = 8;
    localparam int BUSY_TMO  = 8;

    // Bit positions inside the core status/command word {busy, round, W, R}.
    localparam int CMD_BUSY  = 3;
    localparam int CMD_ROUND = 2;
    localparam int CMD_W     = 1;
    localparam int CMD_R     = 0;

    typedef logic [3:0] drv_state_t;

    localparam drv_state_t ST_IDLE    = 4'd0;
    localparam drv_state_t ST_ACCEPT  = 4'd1;
    localparam drv_state_t ST_CMD_W   = 4'd2;
    localparam drv_state_t ST_LOAD    = 4'd3;
    localparam drv_state_t ST_WAIT_HI = 4'd4;
    localparam drv_state_t ST_WAIT_LO = 4'd5;
    localparam drv_state_t ST_CMD_R   = 4'd6;
    localparam drv_state_t ST_READ    = 4'd7;
    localparam drv_state_t ST_DRAIN   = 4'd8;

endpackage

// File: rtl/sha256_drv_wbuf.sv
// Small word register file: synchronous write, combinational read. Used as the
// block buffer and as the digest buffer of the driver.
module sha256_drv_wbuf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sha256_driver.sv
// Buffers a 16-word block from the client, streams it into a SHA-256 core,
// waits for the core to finish, reads the 8-word digest back and drains it.
module sha256_driver #(
    parameter int BLK_WORDS = sha256_drv_pkg::BLK_WORDS,
    parameter int DIG_WORDS = sha256_drv_pkg::DIG_WORDS,
    parameter int BUSY_TMO  = sha256_drv_pkg::BUSY_TMO
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        blk_valid_i,
    input  logic [31:0] blk_data_i,
    input  logic        blk_first_i,
    output logic        blk_ready_o,
    output logic        dig_valid_o,
    output logic [31:0] dig_data_o,
    output logic        dig_last_o,
    input  logic        dig_ready_i,
    output logic        err_o,
    output logic [31:0] core_text_o,
    input  logic [31:0] core_text_i,
    output logic [2:0]  core_cmd_o,
    output logic        core_cmd_w_o,
    input  logic [3:0]  core_cmd_i
);

    import sha256_drv_pkg::*;

    localparam int BAW = $clog2(BLK_WORDS);
    localparam int DAW = $clog2(DIG_WORDS);
    localparam int TAW = $clog2(BUSY_TMO + 1);

    drv_state_t     state_q, state_d;
    logic [BAW-1:0] blk_cnt_q, blk_cnt_d;
    logic [DAW-1:0] dig_cnt_q, dig_cnt_d;
    logic [TAW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic           first_q, first_d;
    logic           rd_arm_q, rd_arm_d;
    logic           err_q, err_d;

    logic           blk_we;
    logic [BAW-1:0] blk_waddr;
    logic [31:0]    blk_rdata;
    logic           dig_we;
    logic [31:0]    dig_rdata;
    logic           core_busy;
    logic           unused_status;

    assign core_busy     = core_cmd_i[CMD_BUSY];
    assign unused_status = ^core_cmd_i[CMD_ROUND:CMD_R];

    sha256_drv_wbuf #(.DEPTH(BLK_WORDS), .WIDTH(32)) u_blk_buf (
        .clk_i   (clk_i),
        .we_i    (blk_we),
        .waddr_i (blk_waddr),
        .wdata_i (blk_data_i),
        .raddr_i (blk_cnt_q),
        .rdata_o (blk_rdata)
    );

    sha256_drv_wbuf #(.DEPTH(DIG_WORDS), .WIDTH(32)) u_dig_buf (
        .clk_i   (clk_i),
        .we_i    (dig_we),
        .waddr_i (dig_cnt_q),
        .wdata_i (core_text_i),
        .raddr_i (dig_cnt_q),
        .rdata_o (dig_rdata)
    );

    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        dig_cnt_d = dig_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        first_d   = first_q;
        rd_arm_d  = rd_arm_q;
        err_d     = 1'b0;
        blk_we    = 1'b0;
        blk_waddr = blk_cnt_q;
        dig_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (blk_valid_i) begin
                    blk_we    = 1'b1;
                    blk_waddr = '0;
                    first_d   = blk_first_i;
                    blk_cnt_d = '0;
                    state_d   = ST_ACCEPT;
                end
            end
            // Word 0 landed in IDLE, so the ACCEPT counter writes one slot ahead.
            ST_ACCEPT: begin
                if (blk_valid_i) begin
                    blk_we    = 1'b1;
                    blk_waddr = blk_cnt_q + 1'b1;
                    if (blk_cnt_q == BAW'(BLK_WORDS - 2)) begin
                        blk_cnt_d = '0;
                        state_d   = ST_CMD_W;
                    end else begin
                        blk_cnt_d = blk_cnt_q + 1'b1;
                    end
                end
            end
            ST_CMD_W: begin
                blk_cnt_d = '0;
                state_d   = ST_LOAD;
            end
            ST_LOAD: begin
                if (blk_cnt_q == BAW'(BLK_WORDS - 1)) begin
                    blk_cnt_d = '0;
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT_HI;
                end else begin
                    blk_cnt_d = blk_cnt_q + 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (core_busy) begin
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT_LO;
                end else if (tmo_cnt_q == TAW'(BUSY_TMO - 1)) begin
                    err_d     = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = ST_CMD_R;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!core_busy) begin
                    state_d = ST_CMD_R;
                end
            end
            ST_CMD_R: begin
                dig_cnt_d = '0;
                rd_arm_d  = 1'b0;
                state_d   = ST_READ;
            end
            // The core needs one cycle after the read command before word 0 appears.
            ST_READ: begin
                if (!rd_arm_q) begin
                    rd_arm_d = 1'b1;
                end else begin
                    dig_we = 1'b1;
                    if (dig_cnt_q == DAW'(DIG_WORDS - 1)) begin
                        dig_cnt_d = '0;
                        rd_arm_d  = 1'b0;
                        state_d   = ST_DRAIN;
                    end else begin
                        dig_cnt_d = dig_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (dig_ready_i) begin
                    if (dig_cnt_q == DAW'(DIG_WORDS - 1)) begin
                        dig_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        dig_cnt_d = dig_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            blk_cnt_q <= '0;
            dig_cnt_q <= '0;
            tmo_cnt_q <= '0;
            first_q   <= 1'b0;
            rd_arm_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_cnt_q <= blk_cnt_d;
            dig_cnt_q <= dig_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            first_q   <= first_d;
            rd_arm_q  <= rd_arm_d;
            err_q     <= err_d;
        end
    end

    // Outputs are forced low while reset is asserted, whatever the state holds.
    always_comb begin
        blk_ready_o  = 1'b0;
        dig_valid_o  = 1'b0;
        dig_data_o   = '0;
        dig_last_o   = 1'b0;
        core_text_o  = '0;
        core_cmd_o   = '0;
        core_cmd_w_o = 1'b0;
        err_o        = err_q & ~rst_i;
        if (!rst_i) begin
            case (state_q)
                ST_IDLE, ST_ACCEPT: begin
                    blk_ready_o = 1'b1;
                end
                ST_CMD_W: begin
                    core_cmd_w_o          = 1'b1;
                    core_cmd_o[CMD_ROUND] = ~first_q;
                    core_cmd_o[CMD_W]     = 1'b1;
                end
                ST_LOAD: begin
                    core_text_o = blk_rdata;
                end
                ST_CMD_R: begin
                    core_cmd_w_o      = 1'b1;
                    core_cmd_o[CMD_R] = 1'b1;
                end
                ST_DRAIN: begin
                    dig_valid_o = 1'b1;
                    dig_data_o  = dig_rdata;
                    dig_last_o  = (dig_cnt_q == DAW'(DIG_WORDS - 1));
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_driver.sv
// Bench for sha256_driver: randomized client traffic, a reactive core model,
// and a scoreboard monitor comparing core and digest traffic to expectations.
module tb_sha256_driver;

    localparam int MODE_BUSY = 0;
    localparam int MODE_TMO  = 1;
    localparam int MODE_RST  = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        blk_valid_i;
    logic [31:0] blk_data_i;
    logic        blk_first_i;
    logic        blk_ready_o;
    logic        dig_valid_o;
    logic [31:0] dig_data_o;
    logic        dig_last_o;
    logic        dig_ready_i;
    logic        err_o;
    logic [31:0] core_text_o;
    logic [31:0] core_text_i;
    logic [2:0]  core_cmd_o;
    logic        core_cmd_w_o;
    logic [3:0]  core_cmd_i;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int err_exp  = 0;
    int rdy_mode = 2;

    logic [31:0] exp_text_q [$];
    logic [31:0] exp_dig_q  [$];
    logic        exp_last_q [$];
    logic [2:0]  exp_cmd_q  [$];
    logic [31:0] core_dig_q [$];
    int          mode_q     [$];

    logic [31:0] stim_w [16];
    logic [31:0] stim_d [8];

    sha256_driver dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .blk_valid_i  (blk_valid_i),
        .blk_data_i   (blk_data_i),
        .blk_first_i  (blk_first_i),
        .blk_ready_o  (blk_ready_o),
        .dig_valid_o  (dig_valid_o),
        .dig_data_o   (dig_data_o),
        .dig_last_o   (dig_last_o),
        .dig_ready_i  (dig_ready_i),
        .err_o        (err_o),
        .core_text_o  (core_text_o),
        .core_text_i  (core_text_i),
        .core_cmd_o   (core_cmd_o),
        .core_cmd_w_o (core_cmd_w_o),
        .core_cmd_i   (core_cmd_i)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctrl"}, 32'({blk_ready_o, dig_valid_o, dig_last_o, err_o, core_cmd_w_o, core_cmd_o}), 32'd0);
        check({tag, "_text"}, core_text_o, 32'd0);
        check({tag, "_dig"}, dig_data_o, 32'd0);
    endtask

    // Driver: pushes expectations for the block, then hands the 16 words over
    // with random gaps. Only word 0 carries a meaningful first flag.
    task automatic send_block(input logic first, input int mode);
        int  gap;
        bit  got;
        exp_cmd_q.push_back(first ? 3'b010 : 3'b110);
        mode_q.push_back(mode);
        for (int i = 0; i < 16; i++) begin
            if (mode != MODE_RST || i < 8) exp_text_q.push_back(stim_w[i]);
        end
        if (mode != MODE_RST) begin
            for (int j = 0; j < 8; j++) begin
                core_dig_q.push_back(stim_d[j]);
                exp_dig_q.push_back(stim_d[j]);
                exp_last_q.push_back(j == 7);
            end
        end
        if (mode == MODE_TMO) err_exp++;
        for (int i = 0; i < 16; i++) begin
            blk_valid_i = 1'b0;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk_i);
                #1;
            end
            blk_valid_i = 1'b1;
            blk_data_i  = stim_w[i];
            blk_first_i = (i == 0) ? first : 1'($urandom);
            got = 1'b0;
            for (int t = 0; t < 400 && !got; t++) begin
                @(negedge clk_i);
                if (blk_ready_o) got = 1'b1;
                @(posedge clk_i);
                #1;
            end
            check("blk_accept", 32'(got), 32'd1);
        end
        blk_valid_i = 1'b0;
        blk_data_i  = $urandom;
    endtask

    task automatic rand_block();
        for (int i = 0; i < 16; i++) stim_w[i] = $urandom;
        for (int j = 0; j < 8; j++) stim_d[j] = $urandom;
    endtask

    // Digest-side ready pattern
    initial begin
        dig_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       dig_ready_i = ~dig_ready_i;
                1:       dig_ready_i = 1'($urandom);
                default: dig_ready_i = 1'b1;
            endcase
        end
    end

    // Core model: reacts to the write command, produces busy (or withholds it),
    // then answers the read command with digest words two cycles later.
    initial begin
        int mode;
        int d;
        int l;
        core_text_i = 32'd0;
        core_cmd_i  = 4'd0;
        forever begin
            @(negedge clk_i);
            if (!rst_i && core_cmd_w_o && core_cmd_o[1]) begin
                mode = (mode_q.size() > 0) ? mode_q.pop_front() : MODE_BUSY;
                if (mode == MODE_RST) continue;
                if (mode == MODE_TMO) begin
                    repeat (24) @(negedge clk_i);
                    check("err_early", 32'(err_o), 32'd0);
                    @(negedge clk_i);
                    check("err_pulse", 32'(err_o), 32'd1);
                    check("cmd_r_after_tmo", 32'({core_cmd_w_o, core_cmd_o}), 32'b1001);
                end else begin
                    repeat (16) @(negedge clk_i);
                    d = $urandom_range(0, 6);
                    l = $urandom_range(1, 5);
                    repeat (d + 1) @(posedge clk_i);
                    #1 core_cmd_i = 4'b1000;
                    repeat (l) @(posedge clk_i);
                    #1 core_cmd_i = 4'b0000;
                    @(negedge clk_i);
                    check("cmd_r_early", 32'(core_cmd_w_o), 32'd0);
                    @(negedge clk_i);
                    check("cmd_r_after_busy", 32'({core_cmd_w_o, core_cmd_o}), 32'b1001);
                end
                @(posedge clk_i);
                #1 core_text_i = $urandom;
                for (int j = 0; j < 8; j++) begin
                    @(posedge clk_i);
                    #1 core_text_i = (core_dig_q.size() > 0) ? core_dig_q.pop_front() : $urandom;
                end
                @(posedge clk_i);
                #1 core_text_i = $urandom;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        int          load_left;
        bit          in_phase;
        logic [31:0] exp_w;
        logic        exp_l;
        load_left = 0;
        in_phase  = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                load_left = 0;
                in_phase  = 1'b0;
            end else begin
                if (load_left > 0) begin
                    if (exp_text_q.size() > 0) check("core_text", core_text_o, exp_text_q.pop_front());
                    load_left--;
                end else begin
                    check("core_text_idle", core_text_o, 32'd0);
                end
                if (core_cmd_w_o) begin
                    if (core_cmd_o[1]) begin
                        if (exp_cmd_q.size() > 0) check("cmd_w", 32'(core_cmd_o), 32'(exp_cmd_q.pop_front()));
                        else check("cmd_w_spurious", 32'(core_cmd_w_o), 32'd0);
                        load_left = 16;
                        in_phase  = 1'b1;
                    end else begin
                        check("cmd_r", 32'(core_cmd_o), 32'b001);
                    end
                end else begin
                    check("cmd_idle", 32'(core_cmd_o), 32'd0);
                end
                if (in_phase) check("blk_ready_busy", 32'(blk_ready_o), 32'd0);
                if (dig_valid_o && dig_ready_i) begin
                    if (exp_dig_q.size() > 0) begin
                        exp_w = exp_dig_q.pop_front();
                        exp_l = exp_last_q.pop_front();
                        check("dig_data", dig_data_o, exp_w);
                        check("dig_last", 32'(dig_last_o), 32'(exp_l));
                        if (exp_l) in_phase = 1'b0;
                    end else begin
                        check("dig_spurious", 32'(dig_valid_o), 32'd0);
                    end
                end
                if (err_o) err_seen++;
            end
        end
    end

    // Main sequence
    initial begin
        rst_i       = 1'b1;
        blk_valid_i = 1'b0;
        blk_data_i  = 32'd0;
        blk_first_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_quiet("reset");
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_reset", 32'(blk_ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        // Known block and digest, first block, toggling digest ready
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) stim_w[i] = 32'(i);
        for (int j = 0; j < 8; j++) stim_d[j] = 32'hA0 + 32'(j);
        send_block(1'b1, MODE_BUSY);

        // Continuation block
        rand_block();
        send_block(1'b0, MODE_BUSY);

        // Busy never rises
        rdy_mode = 1;
        rand_block();
        send_block(1'($urandom), MODE_TMO);

        for (int b = 0; b < 4; b++) begin
            rand_block();
            send_block(1'($urandom), ($urandom_range(0, 2) == 0) ? MODE_TMO : MODE_BUSY);
        end

        // Reset while word 7 is on core_text_o
        rand_block();
        send_block(1'b1, MODE_RST);
        @(negedge clk_i);
        check("rst_test_cmd_w", 32'({core_cmd_w_o, core_cmd_o}), 32'b1010);
        repeat (8) @(negedge clk_i);
        check("rst_test_word7", core_text_o, stim_w[7]);
        #2 rst_i = 1'b1;
        @(negedge clk_i);
        check_quiet("mid_load_reset");
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_mid_reset", 32'({blk_ready_o, dig_valid_o, core_cmd_w_o}), 32'b100);
        @(posedge clk_i);
        #1;

        // Fresh block after reset
        rdy_mode = 0;
        rand_block();
        send_block(1'b1, MODE_BUSY);

        for (int t = 0; t < 600 && exp_dig_q.size() != 0; t++) @(posedge clk_i);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check("dig_queue_drained", 32'(exp_dig_q.size()), 32'd0);
        check("text_queue_drained", 32'(exp_text_q.size()), 32'd0);
        check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);
        check("err_pulse_count", 32'(err_seen), 32'(err_exp));
        check("final_idle", 32'({blk_ready_o, dig_valid_o}), 32'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_driver.md
SHA256_DRIVER -- requirements
Module: sha256_driver

Interface
REQ-001 Parameters SHALL be: BLK_WORDS, 16, words per message block; DIG_WORDS, 8, digest words; BUSY_TMO, 8, max cycles waiting for core busy to rise.
REQ-002 clk_i  input  1  single clock; all logic on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 blk_valid_i  input  1  client block word valid.
REQ-005 blk_data_i  input  32  client block word.
REQ-006 blk_first_i  input  1  sampled with word 0: 1 = first block of message, 0 = continuation.
REQ-007 blk_ready_o  output  1  driver accepts a block word.
REQ-008 dig_valid_o  output  1  digest word valid.
REQ-009 dig_data_o  output  32  digest word, word 0 first.
REQ-010 dig_last_o  output  1  marks digest word 7.
REQ-011 dig_ready_i  input  1  client accepts digest word.
REQ-012 err_o  output  1  one-cycle pulse: busy-rise timeout.
REQ-013 core_text_o  output  32  word to core text input.
REQ-014 core_text_i  input  32  word from core text output.
REQ-015 core_cmd_o  output  3  {round, W, R} to core command input.
REQ-016 core_cmd_w_o  output  1  core command write strobe.
REQ-017 core_cmd_i  input  4  core status {busy, round, W, R}.

Function
REQ-018 Client handshakes SHALL complete on cycles where valid and ready are both high; data is held stable while valid is high and ready is low.
REQ-019 FSM states SHALL be IDLE, ACCEPT, CMD_W, LOAD, WAIT_HI, WAIT_LO, CMD_R, READ, DRAIN.
REQ-020 IDLE: blk_ready_o=1; a handshake stores word 0 and blk_first_i, then -> ACCEPT.
REQ-021 ACCEPT: blk_ready_o=1 until 16 words are stored in order; after word 15 -> CMD_W; no core traffic before all 16 words are buffered.
REQ-022 CMD_W: one cycle, core_cmd_w_o=1, core_cmd_o={~first,1,0}, blk_ready_o=0 -> LOAD.
REQ-023 LOAD: core_text_o SHALL present buffered word k in the k-th cycle after CMD_W (k=0..15), one word per cycle without gaps, then -> WAIT_HI; core_text_o=0 outside LOAD.
REQ-024 WAIT_HI: on core_cmd_i[3]=1 -> WAIT_LO; if not seen within BUSY_TMO cycles, pulse err_o and -> CMD_R.
REQ-025 WAIT_LO: on core_cmd_i[3]=0 -> CMD_R; no timeout.
REQ-026 CMD_R: one cycle, core_cmd_w_o=1, core_cmd_o={0,0,1} -> READ.
REQ-027 READ: digest word j SHALL be captured from core_text_i in the (j+2)-th cycle after CMD_R (j=0..7), unconditionally (core cannot stall), then -> DRAIN.
REQ-028 DRAIN: dig_valid_o=1 presenting words 0..7 in order; dig_last_o=1 with word 7; handshake on word 7 -> IDLE.
REQ-029 dig_valid_o SHALL be 0 in all states except DRAIN; no new block is accepted until the digest fully drains.
REQ-030 Word counters SHALL be 4-bit (block) and 3-bit (digest), reset to 0 on each state entry, no wrap beyond terminal count.
REQ-031 core_cmd_w_o SHALL be high only in CMD_W and CMD_R; core_cmd_o=0 otherwise.

Reset
REQ-032 While rst_i=1 the FSM SHALL be IDLE, counters 0, and all outputs 0 except blk_ready_o (0 during reset, 1 the cycle after release).
REQ-033 Reset in any state SHALL discard buffered block and digest words; no partial digest is emitted afterward.

Structure
REQ-034 Package sha256_drv_pkg SHALL hold the FSM state enum, core command bit positions (BUSY=3, ROUND=2, W=1, R=0), BLK_WORDS, DIG_WORDS, BUSY_TMO.
REQ-035 One sub-module sha256_drv_wbuf (parameterised depth x 32 register file, write index/read index, synchronous write, combinational read) SHALL be instantiated twice: block buffer (16) and digest buffer (8).

Verification
REQ-036 Single block: client sends words 0x00000000..0x0000000F, first=1 -> CMD_W with core_cmd_o=3'b010; core_text_o shows 0x0..0xF on 16 consecutive cycles.
REQ-037 Continuation: first=0 -> core_cmd_o=3'b110 on CMD_W.
REQ-038 Digest: core model drives 0xA0..0xA7 on cycles CMD_R+2..+9 -> dig_data_o emits 0xA0..0xA7, dig_last_o only with 0xA7.
REQ-039 Backpressure: dig_ready_i toggled 1/0 every cycle and blk_valid_i gapped -> all words intact and in order; blk_ready_o=0 from CMD_W to last digest handshake.
REQ-040 Timeout: core busy held 0 -> err_o pulses once 8 cycles after WAIT_HI entry, FSM proceeds to CMD_R.
REQ-041 Reset mid-LOAD at word 7 -> next cycle all outputs 0; after release, fresh 16-word block completes normally with no stale data.
